// File: rtl/pc_seq_ctrl_if.sv
// Purpose : groups the PC-sequencing control signals between the hazard sources / PC block and pc_seq_ctrl.
// Latency : none, this is wiring only.
// Backpressure: none. hazard_detected acts as the PC hold towards the PC block.
// Ports   : inputs are IF/ID rs/rt, ID/EX rt and load flag, branch_taken, jump_req and nxt_pc.
//           Outputs are hazard_detected, br_ctrl_mux_sel, jump_ctrl, ifid_flush, idex_bubble,
//           pc_halted, ctrl_state, stall_cnt and flush_cnt.
//           The master modport is the driving side (pipeline / PC block); the slave modport is the controller.
interface pc_seq_ctrl_if;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic [4:0]  idex_rt;
    logic        idex_mem_read;
    logic        branch_taken;
    logic        jump_req;
    logic [31:0] nxt_pc;

    logic        hazard_detected;
    logic        br_ctrl_mux_sel;
    logic        jump_ctrl;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pc_halted;
    logic [2:0]  ctrl_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output ifid_rs, ifid_rt, idex_rt, idex_mem_read, branch_taken, jump_req, nxt_pc,
        input  hazard_detected, br_ctrl_mux_sel, jump_ctrl, ifid_flush, idex_bubble,
               pc_halted, ctrl_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rt, idex_mem_read, branch_taken, jump_req, nxt_pc,
        output hazard_detected, br_ctrl_mux_sel, jump_ctrl, ifid_flush, idex_bubble,
               pc_halted, ctrl_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Purpose : fetch-stage PC sequencing. Decides stall / branch / jump / flush / halt-drain each cycle.
// Latency : redirect, stall and bubble controls are combinational (0 cycles). The state moves on the next clk.
// Backpressure: hazard_detected freezes the PC on a load-use stall, while draining and once halted.
// Ports   : clk, rst_n (async active-low); bus (pc_seq_ctrl_if.slave) carries every hazard input and control output.
// Option  : define PC_SEQ_PERF_EN to build the saturating 16-bit stall_cnt / flush_cnt counters.
//           Without it, both counters read as 0.
module pc_seq_ctrl #(
    parameter int unsigned HALT_PC_WORD   = 5,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned BR_FLUSH_SLOTS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3
    } state_t;

    // One counter serves both FLUSH and DRAIN, because the two states never overlap.
    // The counter width covers the largest legal parameter value (15).
    localparam logic [3:0]  FLUSH_LOAD = 4'(BR_FLUSH_SLOTS - 1);
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [29:0] HALT_WORD  = 30'(HALT_PC_WORD);
    localparam bit          USE_FLUSH  = (BR_FLUSH_SLOTS > 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic load_use;
    logic halt_hit;
    logic redir_ok;
    logic take_br;
    logic take_jmp;
    logic redirect;
    logic stall;
    logic start_halt;

    always_comb begin
        load_use   = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                     ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
        halt_hit   = (bus.nxt_pc[31:2] == HALT_WORD);
        redir_ok   = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        // A branch outranks a jump in the same cycle, so the jump is dropped.
        take_br    = redir_ok && bus.branch_taken;
        take_jmp   = redir_ok && bus.jump_req && !bus.branch_taken;
        redirect   = take_br || take_jmp;
        // Load-use and halt are only honoured in RUN. While flushing, the IF/ID slot is being discarded anyway.
        stall      = (state_q == ST_RUN) && !redirect && load_use;
        start_halt = (state_q == ST_RUN) && !redirect && !load_use && halt_hit;
    end

    // Outputs that depend on inputs are gated by rst_n.
    // This keeps them at 0 for the whole reset assertion even while the inputs are active.
    assign bus.hazard_detected = rst_n && (stall || (state_q == ST_DRAIN) || (state_q == ST_HALTED));
    assign bus.br_ctrl_mux_sel = rst_n && take_br;
    assign bus.jump_ctrl       = rst_n && take_jmp;
    assign bus.ifid_flush      = rst_n && (redirect || (state_q == ST_FLUSH));
    assign bus.idex_bubble     = rst_n && (take_br || stall);
    assign bus.pc_halted       = (state_q == ST_HALTED);
    assign bus.ctrl_state      = state_q;

    // The FLUSH counter holds the number of FLUSH cycles still to come, so FLUSH exits when it would reach 0.
    // The DRAIN counter holds the number of extra DRAIN cycles, so DRAIN lasts DRAIN_CYCLES cycles in total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN, ST_FLUSH: begin
                if (redirect) begin
                    if (USE_FLUSH) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end
                end else if (state_q == ST_FLUSH) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end else if (start_halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed steps plus randomized traffic, checked against a cycle-count reference model.
module tb_pc_seq_ctrl;
    localparam int HALT_W = 5;
    localparam int DRAIN  = 4;
    localparam int SLOTS  = 2;
`ifdef PC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_seq_ctrl_if bus ();

    pc_seq_ctrl #(
        .HALT_PC_WORD  (HALT_W),
        .DRAIN_CYCLES  (DRAIN),
        .BR_FLUSH_SLOTS(SLOTS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining cycles in each phase, plus event counts.
    int flush_rem;
    int drain_rem;
    bit halted;
    int scnt;
    int fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flush_rem = 0; drain_rem = 0; halted = 0; scnt = 0; fcnt = 0;
    endtask

    task automatic drive(input bit br, input bit jp, input bit mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc);
        bus.branch_taken  = br;
        bus.jump_req      = jp;
        bus.idex_mem_read = mr;
        bus.idex_rt       = xrt;
        bus.ifid_rs       = rs;
        bus.ifid_rt       = rt;
        bus.nxt_pc        = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h100);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".haz"},  32'(bus.hazard_detected), 0);
        chk({tag, ".br"},   32'(bus.br_ctrl_mux_sel), 0);
        chk({tag, ".jmp"},  32'(bus.jump_ctrl), 0);
        chk({tag, ".fl"},   32'(bus.ifid_flush), 0);
        chk({tag, ".bub"},  32'(bus.idex_bubble), 0);
        chk({tag, ".hlt"},  32'(bus.pc_halted), 0);
        chk({tag, ".st"},   32'(bus.ctrl_state), 0);
        chk({tag, ".scnt"}, 32'(bus.stall_cnt), 0);
        chk({tag, ".fcnt"}, 32'(bus.flush_cnt), 0);
    endtask

    // Called at a falling edge with inputs already driven.
    // It checks the outputs, advances the model by one cycle, and returns at the next falling edge.
    task automatic step(input string tag, input bit do_chk);
        bit lu, hh, br, jp;
        logic e_haz, e_br, e_jmp, e_fl, e_bub, e_hlt;
        logic [2:0] e_st;
        #1;
        lu = bus.idex_mem_read && (bus.idex_rt != 0) &&
             (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
        hh = ((bus.nxt_pc >> 2) == 32'(HALT_W));
        br = bus.branch_taken;
        jp = bus.jump_req && !br;
        e_haz = 0; e_br = 0; e_jmp = 0; e_fl = 0; e_bub = 0; e_hlt = 0;
        e_st = halted ? 3'd3 : (drain_rem > 0) ? 3'd2 : (flush_rem > 0) ? 3'd1 : 3'd0;
        if (halted) begin
            e_haz = 1; e_hlt = 1;
        end else if (drain_rem > 0) begin
            e_haz = 1;
        end else begin
            if (br) begin
                e_br = 1; e_fl = 1; e_bub = 1;
            end else if (jp) begin
                e_jmp = 1; e_fl = 1;
            end else if (flush_rem > 0) begin
                e_fl = 1;
            end else if (lu) begin
                e_haz = 1; e_bub = 1;
            end
        end
        if (do_chk) begin
            chk({tag, ".haz"},  32'(bus.hazard_detected), 32'(e_haz));
            chk({tag, ".br"},   32'(bus.br_ctrl_mux_sel), 32'(e_br));
            chk({tag, ".jmp"},  32'(bus.jump_ctrl), 32'(e_jmp));
            chk({tag, ".fl"},   32'(bus.ifid_flush), 32'(e_fl));
            chk({tag, ".bub"},  32'(bus.idex_bubble), 32'(e_bub));
            chk({tag, ".hlt"},  32'(bus.pc_halted), 32'(e_hlt));
            chk({tag, ".st"},   32'(bus.ctrl_state), 32'(e_st));
            chk({tag, ".scnt"}, 32'(bus.stall_cnt), PERF ? 32'(scnt) : 32'd0);
            chk({tag, ".fcnt"}, 32'(bus.flush_cnt), PERF ? 32'(fcnt) : 32'd0);
        end
        if (halted) begin
            // Halted is held until reset.
        end else if (drain_rem > 0) begin
            drain_rem--;
            if (drain_rem == 0) halted = 1;
        end else if (br || jp) begin
            flush_rem = SLOTS - 1;
            if (fcnt < 65535) fcnt++;
        end else if (flush_rem > 0) begin
            flush_rem--;
        end else if (lu) begin
            if (scnt < 65535) scnt++;
        end else if (hh) begin
            drain_rem = DRAIN;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted between clock edges; the outputs must drop without an edge.
    task automatic reset_mid(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use stall for one cycle, then the same pattern with rt=0.
        drive(0, 0, 1, 5'd8, 5'd8, 5'd3, 32'h100); step("lu", 1);
        idle();                                    step("lu_after", 1);
        drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 32'h100); step("lu_rt0", 1);
        drive(0, 0, 1, 5'd9, 5'd1, 5'd9, 32'h100); step("lu_rt_match", 1);
        drive(0, 0, 1, 5'd9, 5'd1, 5'd9, 32'h100); step("lu_persist", 1);
        idle();                                    step("lu_idle", 1);

        // Taken branch, followed by the flush window.
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("br", 1);
        idle();                                    step("br_fl1", 1);
        idle();                                    step("br_run", 1);

        // Branch together with jump, then load-use during FLUSH, then jump inside FLUSH.
        drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("br_jmp", 1);
        drive(0, 0, 1, 5'd8, 5'd8, 5'd0, 32'h100); step("lu_in_flush", 1);
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("jmp", 1);
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("jmp_in_flush", 1);
        idle();                                    step("jmp_fl", 1);
        idle();                                    step("jmp_run", 1);

        // Branch together with halt_hit: the branch wins.
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h14);  step("br_halt", 1);
        idle();                                    step("br_halt_fl", 1);

        // Halt-drain: jump_req is ignored while draining, then the core stays halted.
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h14);  step("halt", 1);
        for (int i = 0; i < DRAIN; i++) begin
            drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("drain", 1);
        end
        for (int i = 0; i < 100; i++) begin
            drive(i[0], ~i[0], 1, 5'd8, 5'd8, 5'd8, 32'h14); step("halted", 1);
        end

        // Reset in the middle of DRAIN.
        reset_mid("rst_halted");
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h17); step("halt2", 1);
        idle();                                    step("drain2", 1);
        drive(1, 1, 1, 5'd8, 5'd8, 5'd8, 32'h100);
        reset_mid("rst_drain");
        drive(0, 0, 1, 5'd4, 5'd1, 5'd4, 32'h100); step("post_rst_lu", 1);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h100); step("post_rst_br", 1);
        idle();                                    step("post_rst_idle", 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 24) == 0) ? (32'h14 | 32'($urandom_range(0, 3)))
                                              : $urandom();
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), pc);
            if (halted && $urandom_range(0, 5) == 0) begin
                reset_mid("rnd_rst");
            end else begin
                step("rnd", 1);
            end
        end

`ifdef PC_SEQ_PERF_EN
        // Stall counter saturation.
        reset_mid("sat_rst");
        drive(0, 0, 1, 5'd8, 5'd8, 5'd0, 32'h100);
        for (int i = 0; i < 70000; i++) step("sat_run", 0);
        chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
        step("sat_hold", 1);
        step("sat_hold2", 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
